// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch front end.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned DEFAULT_CORE_WIDTH = 2;
  localparam int unsigned FETCH_BYTES        = 4 * DEFAULT_CORE_WIDTH;

  // Default-width queue entry; the top re-declares this shape for its own CORE_WIDTH.
  typedef struct packed {
    logic [31:0]                       pc;
    logic [DEFAULT_CORE_WIDTH*32-1:0]  blk;
  } fetch_entry_t;

  function automatic logic [31:0] fetch_step(int unsigned core_width);
    return 32'(4 * core_width);
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Instruction memory, redirect and decode-side signals of the fetch controller.
interface fetch_controller_if #(
  parameter int unsigned CORE_WIDTH = 2,
  parameter int unsigned FQ_DEPTH   = 4
);

  logic [31:0]               pc_addr;
  logic [CORE_WIDTH*32-1:0]  instruction_blk;
  logic                      redirect_valid;
  logic [31:0]               redirect_pc;
  logic                      fetch_valid;
  logic                      fetch_ready;
  logic [CORE_WIDTH*32-1:0]  fetch_blk;
  logic [31:0]               fetch_pc;
  logic [$clog2(FQ_DEPTH):0] fq_count;

  modport master (
    output pc_addr, fetch_valid, fetch_blk, fetch_pc, fq_count,
    input  instruction_blk, redirect_valid, redirect_pc, fetch_ready
  );

  modport slave (
    input  pc_addr, fetch_valid, fetch_blk, fetch_pc, fq_count,
    output instruction_blk, redirect_valid, redirect_pc, fetch_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Circular fetch queue with flush; head entry is read combinationally.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned FQ_DEPTH = 4,
  parameter type         entry_t  = fetch_entry_t
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enq,
  input  entry_t                    enq_data,
  input  logic                      deq,
  input  logic                      flush,
  output entry_t                    head_data,
  output logic [$clog2(FQ_DEPTH):0] count
);

  localparam int unsigned PtrW = $clog2(FQ_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  entry_t            mem_q [FQ_DEPTH];
  logic [PtrW-1:0]   head_q, tail_q;
  logic [CntW-1:0]   count_q, count_d;

  // Caller guarantees enq only when there is room (or a same-cycle deq) and deq only when non-empty.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      unique case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(FQ_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (enq) begin
        mem_q[tail_q] <= enq_data;
        tail_q        <= tail_q + 1'b1;
      end
      if (deq) begin
        head_q <= head_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  assign head_data = mem_q[head_q];
  assign count     = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Fetch PC sequencer: streams instruction blocks into the fetch queue, retargets on redirect.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned CORE_WIDTH = 2,
  parameter int unsigned FQ_DEPTH   = 4,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic                clk,
  input logic                rst,
  fetch_controller_if.master bus
);

  localparam int unsigned CntW    = $clog2(FQ_DEPTH) + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FQ_DEPTH);
  localparam logic [31:0] PcStep = fetch_step(CORE_WIDTH);

  typedef struct packed {
    logic [31:0]              pc;
    logic [CORE_WIDTH*32-1:0] blk;
  } entry_t;

  logic [31:0]     pc_q;
  logic [CntW-1:0] count;
  logic            fetch_valid;
  logic            dequeue;
  logic            enqueue;
  entry_t          enq_data;
  entry_t          head_data;
  logic            unused_rpc_lo;

  assign fetch_valid = (count != '0);
  assign dequeue     = fetch_valid & bus.fetch_ready;
  // A full queue still accepts a block when decode frees the head in the same cycle.
  assign enqueue     = ~bus.redirect_valid & ((count < DepthCnt) | dequeue);

  assign enq_data.pc  = pc_q;
  assign enq_data.blk = bus.instruction_blk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (bus.redirect_valid) begin
      pc_q <= {bus.redirect_pc[31:2], 2'b00};
    end else if (enqueue) begin
      pc_q <= pc_q + PcStep;
    end
  end

  fetch_queue #(
    .FQ_DEPTH (FQ_DEPTH),
    .entry_t  (entry_t)
  ) u_fetch_queue (
    .clk       (clk),
    .rst       (rst),
    .enq       (enqueue),
    .enq_data  (enq_data),
    .deq       (dequeue),
    .flush     (bus.redirect_valid),
    .head_data (head_data),
    .count     (count)
  );

  assign bus.pc_addr     = pc_q;
  assign bus.fetch_valid = fetch_valid;
  assign bus.fetch_pc    = head_data.pc;
  assign bus.fetch_blk   = head_data.blk;
  assign bus.fq_count    = count;

  assign unused_rpc_lo = ^bus.redirect_pc[1:0];

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller against a queue-based reference model.
module tb_fetch_controller;
  import fetch_pkg::*;

  localparam int unsigned CW    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned BW    = CW * 32;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] imem [128];
  int          imem_gen = 0;
  logic [31:0] mq [$];
  logic [31:0] m_pc;
  logic [31:0] seen [$];

  fetch_controller_if #(.CORE_WIDTH(CW), .FQ_DEPTH(DEPTH)) bus ();

  fetch_controller #(
    .CORE_WIDTH (CW),
    .FQ_DEPTH   (DEPTH),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] blk_at(logic [31:0] pc);
    logic [BW-1:0] b;
    logic [31:0]   a;
    b = '0;
    for (int i = 0; i < int'(CW); i++) begin
      a = pc + 32'(4 * i);
      b[i*32 +: 32] = (a < 32'd512) ? imem[a[8:2]] : NOP_INSTR;
    end
    return b;
  endfunction

  always @(bus.pc_addr, imem_gen) bus.instruction_blk = blk_at(bus.pc_addr);

  // One clock of the reference model: decode pops the head, fetch appends the current pc.
  task automatic cycle();
    logic deq, enq;
    if (bus.fetch_valid === 1'b1 && bus.fetch_ready && !bus.redirect_valid)
      seen.push_back(bus.fetch_pc);
    deq = (mq.size() != 0) && bus.fetch_ready;
    if (bus.redirect_valid) begin
      mq.delete();
      m_pc = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      enq = (mq.size() < DEPTH) || deq;
      if (deq) mq.delete(0);
      if (enq) begin
        mq.push_back(m_pc);
        m_pc = m_pc + 32'd8;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.fetch_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    seen.delete();
    m_pc = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.fetch_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.fetch_valid !== 1'b0 || bus.fq_count !== 3'd0) begin
      failures++;
      $display("FAIL reset_state valid=%b count=%0d required valid=0 count=0",
               bus.fetch_valid, bus.fq_count);
    end
    checks++;
    if (bus.pc_addr !== 32'h0 || bus.fetch_pc !== 32'h0 || bus.fetch_blk !== '0) begin
      failures++;
      $display("FAIL reset_regs pc_addr=%h fetch_pc=%h blk=%h required all zero",
               bus.pc_addr, bus.fetch_pc, bus.fetch_blk);
    end
    do_reset();
  endtask

  task automatic test_stream();
    logic [BW-1:0] exp_blk;
    do_reset();
    bus.fetch_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      exp_blk = {imem[2*k-1], imem[2*k-2]};
      checks++;
      if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== 32'(8*(k-1)) || bus.fetch_blk !== exp_blk)
      begin
        failures++;
        $display("FAIL stream_%0d valid=%b pc=%h blk=%h required valid=1 pc=%h blk=%h", k,
                 bus.fetch_valid, bus.fetch_pc, bus.fetch_blk, 32'(8*(k-1)), exp_blk);
      end
      checks++;
      if (bus.fq_count !== 3'd1 || bus.pc_addr !== 32'(8*k)) begin
        failures++;
        $display("FAIL stream_cnt_%0d count=%0d pc_addr=%h required count=1 pc_addr=%h", k,
                 bus.fq_count, bus.pc_addr, 32'(8*k));
      end
    end
  endtask

  task automatic test_stall();
    int budget;
    logic [31:0] exp_seq [5];
    exp_seq = '{32'h00, 32'h08, 32'h10, 32'h18, 32'h20};
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      cycle();
      checks++;
      if (bus.fq_count !== 3'((k < 4) ? k : 4)) begin
        failures++;
        $display("FAIL stall_count_%0d count=%0d required %0d", k, bus.fq_count,
                 (k < 4) ? k : 4);
      end
    end
    checks++;
    if (bus.pc_addr !== 32'h20) begin
      failures++;
      $display("FAIL stall_pc_hold pc_addr=%h required 00000020", bus.pc_addr);
    end
    bus.fetch_ready = 1'b1;
    budget = 0;
    while (seen.size() < 5 && budget < 20) begin
      cycle();
      budget++;
    end
    checks++;
    if (seen.size() < 5) begin
      failures++;
      $display("FAIL stall_drain_timeout delivered=%0d required 5", seen.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (seen[i] !== exp_seq[i]) begin
          failures++;
          $display("FAIL stall_order_%0d pc=%h required %h", i, seen[i], exp_seq[i]);
        end
      end
    end
  endtask

  task automatic test_full_concurrent();
    logic [31:0] exp_heads [3];
    exp_heads = '{32'h10, 32'h18, 32'h20};
    do_reset();
    repeat (5) cycle();
    bus.fetch_ready = 1'b1;
    cycle();
    checks++;
    if (bus.fq_count !== 3'd4 || bus.pc_addr !== 32'h28 || bus.fetch_pc !== 32'h08) begin
      failures++;
      $display("FAIL full_concurrent count=%0d pc_addr=%h head=%h required 4 00000028 00000008",
               bus.fq_count, bus.pc_addr, bus.fetch_pc);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (bus.fetch_pc !== exp_heads[i]) begin
        failures++;
        $display("FAIL full_tail_%0d head=%h required %h", i, bus.fetch_pc, exp_heads[i]);
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (3) cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    cycle();
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.fetch_valid !== 1'b0 || bus.fq_count !== 3'd0 || bus.pc_addr !== 32'h100) begin
      failures++;
      $display("FAIL redirect_flush valid=%b count=%0d pc_addr=%h required 0 0 00000100",
               bus.fetch_valid, bus.fq_count, bus.pc_addr);
    end
    cycle();
    checks++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== 32'h100 ||
        bus.fetch_blk !== {imem[65], imem[64]}) begin
      failures++;
      $display("FAIL redirect_target valid=%b pc=%h blk=%h required 1 00000100 %h",
               bus.fetch_valid, bus.fetch_pc, bus.fetch_blk, {imem[65], imem[64]});
    end
  endtask

  task automatic test_redirect_full_deq();
    logic [31:0] tgt;
    do_reset();
    repeat (4) cycle();
    tgt = $urandom_range(0, 120) * 4 + $urandom_range(0, 3);
    bus.fetch_ready    = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = tgt;
    cycle();
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.fetch_valid !== 1'b0 || bus.fq_count !== 3'd0 ||
        bus.pc_addr !== {tgt[31:2], 2'b00}) begin
      failures++;
      $display("FAIL redirect_full_flush valid=%b count=%0d pc_addr=%h required 0 0 %h",
               bus.fetch_valid, bus.fq_count, bus.pc_addr, {tgt[31:2], 2'b00});
    end
    for (int k = 0; k < 10; k++) begin
      bus.fetch_ready = 1'($urandom_range(0, 1));
      cycle();
      checks++;
      if (bus.fq_count !== 3'(mq.size()) ||
          (mq.size() != 0 && bus.fetch_pc !== mq[0])) begin
        failures++;
        $display("FAIL redirect_no_stale_%0d count=%0d head=%h required count=%0d head=%h", k,
                 bus.fq_count, bus.fetch_pc, mq.size(), (mq.size() != 0) ? mq[0] : 32'h0);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.fetch_ready = 1'b1;
    repeat (2) cycle();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0040;
    cycle();
    bus.redirect_pc    = 32'h0000_0080;
    cycle();
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.fetch_valid !== 1'b0 || bus.fq_count !== 3'd0 || bus.pc_addr !== 32'h80) begin
      failures++;
      $display("FAIL b2b_flush valid=%b count=%0d pc_addr=%h required 0 0 00000080",
               bus.fetch_valid, bus.fq_count, bus.pc_addr);
    end
    cycle();
    checks++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== 32'h80) begin
      failures++;
      $display("FAIL b2b_last_wins valid=%b pc=%h required 1 00000080",
               bus.fetch_valid, bus.fetch_pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF8;
    cycle();
    bus.redirect_valid = 1'b0;
    cycle();
    checks++;
    if (bus.fetch_pc !== 32'hFFFF_FFF8 || bus.fetch_blk !== {NOP_INSTR, NOP_INSTR} ||
        bus.pc_addr !== 32'h0) begin
      failures++;
      $display("FAIL wrap_top head=%h blk=%h pc_addr=%h required fffffff8 nop-block 00000000",
               bus.fetch_pc, bus.fetch_blk, bus.pc_addr);
    end
    bus.fetch_ready = 1'b1;
    cycle();
    checks++;
    if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== 32'h0) begin
      failures++;
      $display("FAIL wrap_next valid=%b head=%h required 1 00000000",
               bus.fetch_valid, bus.fetch_pc);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    repeat (2) cycle();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.fetch_valid !== 1'b0 || bus.fq_count !== 3'd0 || bus.pc_addr !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset valid=%b count=%0d pc_addr=%h required 0 0 00000000",
               bus.fetch_valid, bus.fq_count, bus.pc_addr);
    end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 300; k++) begin
      bus.fetch_ready    = ($urandom_range(0, 3) != 0);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      bus.redirect_pc    = $urandom & 32'h0000_01FF;
      cycle();
      checks++;
      if (bus.fetch_valid !== (mq.size() != 0) || bus.fq_count !== 3'(mq.size()) ||
          bus.pc_addr !== m_pc) begin
        failures++;
        $display("FAIL random_state_%0d valid=%b count=%0d pc_addr=%h required %b %0d %h", k,
                 bus.fetch_valid, bus.fq_count, bus.pc_addr, (mq.size() != 0), mq.size(), m_pc);
      end
      if (mq.size() != 0) begin
        checks++;
        if (bus.fetch_pc !== mq[0] || bus.fetch_blk !== blk_at(mq[0])) begin
          failures++;
          $display("FAIL random_head_%0d pc=%h blk=%h required %h %h", k,
                   bus.fetch_pc, bus.fetch_blk, mq[0], blk_at(mq[0]));
        end
      end
    end
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) imem[i] = $urandom;
    imem_gen = 1;
    test_reset();
    test_stream();
    test_stall();
    test_full_concurrent();
    test_redirect();
    test_redirect_full_deq();
    test_back_to_back();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
